// File: rtl/hardwired_control_unit_pkg.sv
// Shared encodings for the hardwired control unit: states, opcodes, select codes
// and the packed control word that drives the accumulator datapath.
package hardwired_control_unit_pkg;

   localparam int DATA_W = 8;
   localparam int IR_W   = 16;

   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_O = 3;

   typedef enum logic [2:0] {
      S_INIT = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   localparam logic [3:0] OP_LD  = 4'h0;
   localparam logic [3:0] OP_ST  = 4'h1;
   localparam logic [3:0] OP_LDI = 4'h2;
   localparam logic [3:0] OP_MOV = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_SUB = 4'h5;
   localparam logic [3:0] OP_AND = 4'h6;
   localparam logic [3:0] OP_OR  = 4'h7;
   localparam logic [3:0] OP_XOR = 4'h8;
   localparam logic [3:0] OP_NOT = 4'h9;
   localparam logic [3:0] OP_LSL = 4'hA;
   localparam logic [3:0] OP_LSR = 4'hB;
   localparam logic [3:0] OP_BRA = 4'hC;
   localparam logic [3:0] OP_BNE = 4'hD;
   localparam logic [3:0] OP_INC = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [1:0] FS_DEC  = 2'b00;
   localparam logic [1:0] FS_INC  = 2'b01;
   localparam logic [1:0] FS_LOAD = 2'b10;
   localparam logic [1:0] FS_CLR  = 2'b11;

   localparam logic [3:0] ALU_PASS_A = 4'b0000;
   localparam logic [3:0] ALU_NOT    = 4'b0011;
   localparam logic [3:0] ALU_ADD    = 4'b0100;
   localparam logic [3:0] ALU_SUB    = 4'b0110;
   localparam logic [3:0] ALU_AND    = 4'b0111;
   localparam logic [3:0] ALU_OR     = 4'b1000;
   localparam logic [3:0] ALU_XOR    = 4'b1001;
   localparam logic [3:0] ALU_LSL    = 4'b1010;
   localparam logic [3:0] ALU_LSR    = 4'b1011;

   localparam logic [1:0] MUXA_IR   = 2'b00;
   localparam logic [1:0] MUXA_MEM  = 2'b01;
   localparam logic [1:0] MUXA_ARFC = 2'b10;
   localparam logic [1:0] MUXA_ALU  = 2'b11;
   localparam logic [1:0] MUXB_IR   = 2'b01;
   localparam logic [1:0] MUXB_MEM  = 2'b10;
   localparam logic [1:0] MUXB_ALU  = 2'b11;
   localparam logic       MUXC_ARF  = 1'b0;
   localparam logic       MUXC_RF   = 1'b1;

   localparam logic [1:0] ARF_PC = 2'b00;
   localparam logic [1:0] ARF_AR = 2'b10;
   localparam logic [1:0] ARF_SP = 2'b11;

   localparam logic [2:0] ARF_EN_NONE = 3'b111;
   localparam logic [2:0] ARF_EN_ALL  = 3'b000;
   localparam logic [2:0] ARF_EN_PC   = 3'b110;
   localparam logic [2:0] ARF_EN_AR   = 3'b101;
   localparam logic [3:0] RF_EN_NONE  = 4'b1111;
   localparam logic [3:0] RF_EN_ALL   = 4'b0000;

   typedef struct packed {
      logic [1:0] rf_out_a_sel;
      logic [1:0] rf_out_b_sel;
      logic [1:0] rf_fun_sel;
      logic [3:0] rf_reg_sel;
      logic [3:0] alu_fun_sel;
      logic [1:0] arf_out_c_sel;
      logic [1:0] arf_out_d_sel;
      logic [1:0] arf_fun_sel;
      logic [2:0] arf_reg_sel;
      logic       ir_lh;
      logic       ir_enable;
      logic [1:0] ir_fun_sel;
      logic       mem_wr;
      logic       mem_cs;
      logic [1:0] mux_a_sel;
      logic [1:0] mux_b_sel;
      logic       mux_c_sel;
      logic       halted;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{
      rf_out_a_sel: 2'b00, rf_out_b_sel: 2'b00, rf_fun_sel: FS_LOAD, rf_reg_sel: RF_EN_NONE,
      alu_fun_sel: ALU_PASS_A, arf_out_c_sel: ARF_PC, arf_out_d_sel: ARF_PC,
      arf_fun_sel: FS_LOAD, arf_reg_sel: ARF_EN_NONE, ir_lh: 1'b0, ir_enable: 1'b0,
      ir_fun_sel: FS_LOAD, mem_wr: 1'b0, mem_cs: 1'b1, mux_a_sel: MUXA_IR,
      mux_b_sel: 2'b00, mux_c_sel: MUXC_ARF, halted: 1'b0
   };

   // Register-file enables are active-low, one bit per register R1..R4.
   function automatic logic [3:0] rf_enable(input logic [1:0] code);
      return ~(4'b0001 << code);
   endfunction

   function automatic logic [3:0] alu_code(input logic [3:0] opc);
      case (opc)
         OP_ADD:  return ALU_ADD;
         OP_SUB:  return ALU_SUB;
         OP_AND:  return ALU_AND;
         OP_OR:   return ALU_OR;
         OP_XOR:  return ALU_XOR;
         OP_LSL:  return ALU_LSL;
         OP_LSR:  return ALU_LSR;
         default: return ALU_PASS_A;
      endcase
   endfunction

endpackage

// File: rtl/hardwired_control_unit_cu_decoder.sv
// Combinational decode of state, instruction high byte and ALU flags into the
// full datapath control word.
module cu_decoder
   import hardwired_control_unit_pkg::*;
(
   input  state_t            state,
   input  logic [DATA_W-1:0] ir_hi,
   input  logic [3:0]        flags,
   output ctrl_t             ctrl
);

   logic [3:0] opc;
   logic [1:0] rd;
   logic [1:0] rs;
   logic       unused_flags;

   assign opc          = ir_hi[7:4];
   assign rd           = ir_hi[3:2];
   assign rs           = ir_hi[1:0];
   assign unused_flags = ^{flags[FLAG_C], flags[FLAG_N], flags[FLAG_O]};

   always_comb begin
      ctrl = CTRL_IDLE;
      case (state)
         S_INIT: begin
            ctrl.rf_reg_sel  = RF_EN_ALL;
            ctrl.rf_fun_sel  = FS_CLR;
            ctrl.arf_reg_sel = ARF_EN_ALL;
            ctrl.arf_fun_sel = FS_CLR;
         end
         S_T0, S_T1: begin
            ctrl.arf_out_d_sel = ARF_PC;
            ctrl.mem_cs        = 1'b0;
            ctrl.ir_enable     = 1'b1;
            ctrl.ir_fun_sel    = FS_LOAD;
            ctrl.ir_lh         = (state == S_T1);
            ctrl.arf_reg_sel   = ARF_EN_PC;
            ctrl.arf_fun_sel   = FS_INC;
         end
         S_T2: begin
            case (opc)
               OP_LD, OP_ST: begin
                  ctrl.mux_b_sel   = MUXB_IR;
                  ctrl.arf_reg_sel = ARF_EN_AR;
               end
               OP_LDI: begin
                  ctrl.mux_a_sel  = MUXA_IR;
                  ctrl.rf_reg_sel = rf_enable(rd);
               end
               OP_MOV: begin
                  ctrl.rf_out_a_sel = rs;
                  ctrl.mux_c_sel    = MUXC_RF;
                  ctrl.mux_a_sel    = MUXA_ALU;
                  ctrl.rf_reg_sel   = rf_enable(rd);
               end
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                  ctrl.rf_out_a_sel = rd;
                  ctrl.rf_out_b_sel = rs;
                  ctrl.mux_c_sel    = MUXC_RF;
                  ctrl.alu_fun_sel  = alu_code(opc);
                  ctrl.mux_a_sel    = MUXA_ALU;
                  ctrl.rf_reg_sel   = rf_enable(rd);
               end
               OP_NOT: begin
                  ctrl.rf_out_b_sel = rs;
                  ctrl.alu_fun_sel  = ALU_NOT;
                  ctrl.mux_a_sel    = MUXA_ALU;
                  ctrl.rf_reg_sel   = rf_enable(rd);
               end
               OP_LSL, OP_LSR: begin
                  ctrl.rf_out_a_sel = rd;
                  ctrl.mux_c_sel    = MUXC_RF;
                  ctrl.alu_fun_sel  = alu_code(opc);
                  ctrl.mux_a_sel    = MUXA_ALU;
                  ctrl.rf_reg_sel   = rf_enable(rd);
               end
               OP_BRA: begin
                  ctrl.mux_b_sel   = MUXB_IR;
                  ctrl.arf_reg_sel = ARF_EN_PC;
               end
               OP_BNE: begin
                  if (!flags[FLAG_Z]) begin
                     ctrl.mux_b_sel   = MUXB_IR;
                     ctrl.arf_reg_sel = ARF_EN_PC;
                  end
               end
               OP_INC: begin
                  ctrl.rf_fun_sel = FS_INC;
                  ctrl.rf_reg_sel = rf_enable(rd);
               end
               // HLT issues nothing here; the state machine moves to HALT.
               default: ;
            endcase
         end
         S_T3: begin
            case (opc)
               OP_LD: begin
                  ctrl.arf_out_d_sel = ARF_AR;
                  ctrl.mem_cs        = 1'b0;
                  ctrl.mux_a_sel     = MUXA_MEM;
                  ctrl.rf_reg_sel    = rf_enable(rd);
               end
               OP_ST: begin
                  ctrl.rf_out_a_sel  = rs;
                  ctrl.mux_c_sel     = MUXC_RF;
                  ctrl.alu_fun_sel   = ALU_PASS_A;
                  ctrl.arf_out_d_sel = ARF_AR;
                  ctrl.mem_cs        = 1'b0;
                  ctrl.mem_wr        = 1'b1;
               end
               default: ;
            endcase
         end
         S_HALT: ctrl.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/hardwired_control_unit.sv
// Hardwired control unit top: state register and sequencing; all control
// outputs come from the combinational decoder.
module hardwired_control_unit
   import hardwired_control_unit_pkg::*;
(
   input  logic            Clock,
   input  logic            Reset,
   input  logic [IR_W-1:0] IR_In,
   input  logic [3:0]      Flags,
   output logic [1:0]      RF_OutASel,
   output logic [1:0]      RF_OutBSel,
   output logic [1:0]      RF_FunSel,
   output logic [3:0]      RF_RegSel,
   output logic [3:0]      ALU_FunSel,
   output logic [1:0]      ARF_OutCSel,
   output logic [1:0]      ARF_OutDSel,
   output logic [1:0]      ARF_FunSel,
   output logic [2:0]      ARF_RegSel,
   output logic            IR_LH,
   output logic            IR_Enable,
   output logic [1:0]      IR_Funsel,
   output logic            Mem_WR,
   output logic            Mem_CS,
   output logic [1:0]      MuxASel,
   output logic [1:0]      MuxBSel,
   output logic            MuxCSel,
   output logic            Halted,
   output logic [2:0]      SC
);

   state_t     state;
   state_t     next_state;
   ctrl_t      ctrl;
   logic [3:0] opc;
   logic       unused_ir;

   assign opc       = IR_In[IR_W-1 -: 4];
   assign unused_ir = ^IR_In[IR_W-DATA_W-1:0];

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= S_INIT;
      else       state <= next_state;
   end

   // LD/ST need a second execute cycle for the memory access; HLT parks in HALT.
   always_comb begin
      next_state = state;
      case (state)
         S_INIT: next_state = S_T0;
         S_T0:   next_state = S_T1;
         S_T1:   next_state = S_T2;
         S_T2: begin
            if (opc == OP_HLT)                      next_state = S_HALT;
            else if (opc == OP_LD || opc == OP_ST)  next_state = S_T3;
            else                                    next_state = S_T0;
         end
         S_T3:   next_state = S_T0;
         S_HALT: next_state = S_HALT;
         default: next_state = S_INIT;
      endcase
   end

   cu_decoder u_decoder (
      .state (state),
      .ir_hi (IR_In[IR_W-1 -: DATA_W]),
      .flags (Flags),
      .ctrl  (ctrl)
   );

   assign RF_OutASel  = ctrl.rf_out_a_sel;
   assign RF_OutBSel  = ctrl.rf_out_b_sel;
   assign RF_FunSel   = ctrl.rf_fun_sel;
   assign RF_RegSel   = ctrl.rf_reg_sel;
   assign ALU_FunSel  = ctrl.alu_fun_sel;
   assign ARF_OutCSel = ctrl.arf_out_c_sel;
   assign ARF_OutDSel = ctrl.arf_out_d_sel;
   assign ARF_FunSel  = ctrl.arf_fun_sel;
   assign ARF_RegSel  = ctrl.arf_reg_sel;
   assign IR_LH       = ctrl.ir_lh;
   assign IR_Enable   = ctrl.ir_enable;
   assign IR_Funsel   = ctrl.ir_fun_sel;
   assign Mem_WR      = ctrl.mem_wr;
   assign Mem_CS      = ctrl.mem_cs;
   assign MuxASel     = ctrl.mux_a_sel;
   assign MuxBSel     = ctrl.mux_b_sel;
   assign MuxCSel     = ctrl.mux_c_sel;
   assign Halted      = ctrl.halted;
   assign SC          = state;

endmodule

// File: doc/hardwired_control_unit.md
Name: hardwired_control_unit

Overview:
Hardwired control unit for the 8-bit accumulator-style datapath (RegFile R1-R4, ARF PC/AR/SP, 16-bit IR, ALU, 256x8 memory). It directly drives every control input of the datapath top: select lines, FunSels, RegSels, IR_LH/IR_Enable, Mem_WR/Mem_CS and MuxA/B/C.
- Sequences fetch (2 bytes), decode and execute using a small state machine.
- Consumes the IR contents and the ALU flags as its only feedback.

Parameters:
DATA_W, 8, datapath/byte width
IR_W, 16, instruction width (two bytes)

Ports:
Clock  in  1  system clock; all state changes on the rising edge
Reset  in  1  asynchronous, active-high; forces state INIT
IR_In  in  16  IR output; [15:12] OPC, [11:10] RD, [9:8] RS, [7:0] ADDR/IMM
Flags  in  4  ALU OutFlag: [0]=Z, [1]=C, [2]=N, [3]=O
RF_OutASel, RF_OutBSel, RF_FunSel  out  2 each  RegFile controls
RF_RegSel  out  4  active-low enables; bit i = R(i+1)
ALU_FunSel  out  4  ALU operation
ARF_OutCSel, ARF_OutDSel, ARF_FunSel  out  2 each  ARF controls (00=PC, 10=AR, 11=SP)
ARF_RegSel  out  3  active-low; [0]=PC, [1]=AR, [2]=SP
IR_LH  out  1  0 loads IR[15:8], 1 loads IR[7:0]
IR_Enable, IR_Funsel  out  1, 2  IR controls
Mem_WR, Mem_CS  out  1 each  1=write; CS active-low
MuxASel, MuxBSel  out  2 each  RF input (00 IR, 01 Mem, 10 ARF C, 11 ALU); ARF input (01 IR, 10 Mem, 11 ALU)
MuxCSel  out  1  ALU A source: 1=RF OutA, 0=ARF OutC
Halted  out  1  high in HALT state
SC  out  3  current state encoding, debug

Behaviour:
- Register FunSel encoding: 00 dec, 01 inc, 10 load, 11 clear.
- States: INIT, T0, T1, T2, T3, HALT. Outputs are combinational from state, IR_In and Flags.
- Idle values in every state unless overridden:
  - RegSels all 1; IR_Enable=0; Mem_CS=1; Mem_WR=0.
  - All FunSels=10; ALU_FunSel=0000; all out-selects and muxes 0.
  - RF_FunSel is never 11 outside INIT, because 11 also clears the ALU flags.
- Reset asserted: state=INIT immediately. Outputs during reset equal the INIT outputs; Halted=0.
- INIT (one cycle after reset release):
  - RF_RegSel=0000, RF_FunSel=11; ARF_RegSel=000, ARF_FunSel=11. This clears R1-R4, PC, AR, SP and the ALU flags.
  - Transition to T0.
- T0: OutDSel=00, Mem_CS=0, IR_Enable=1, IR_Funsel=10, IR_LH=0; PC inc (ARF_RegSel=110, FunSel=01); go to T1.
- T1: as T0 with IR_LH=1; go to T2. IR_In is valid from T2 onward.
- T2/T3 execute, by OPC. RD/RS map to RegSel = ~(1<<code) and OutASel/OutBSel = code.
  - 0 LD: T2 AR<-ADDR (MuxB=01, ARF_RegSel=101, load). T3 RD<-Mem (OutDSel=10, CS=0, MuxA=01, load).
  - 1 ST: T2 AR<-ADDR. T3 Mem[AR]<-RS (OutASel=RS, MuxC=1, ALU 0000, OutDSel=10, CS=0, WR=1).
  - 2 LDI: T2 RD<-IMM (MuxA=00).
  - 3 MOV: T2 RD<-RS (OutASel=RS, MuxC=1, ALU 0000, MuxA=11).
  - 4-8 ADD/SUB/AND/OR/XOR: T2 RD<-RD op RS. A=RD via MuxC=1, B=RS, ALU 0100/0110/0111/1000/1001, MuxA=11.
  - 9 NOT: RD<-~RS (ALU 0011, OutBSel=RS).
  - A LSL / B LSR: RD<-RD shifted (ALU 1010/1011).
  - C BRA: T2 PC<-ADDR (MuxB=01, ARF_RegSel=110, load).
  - D BNE: if Flags[0]==0, as BRA; else no-op. Z is sampled in T2.
  - E INC: RD inc (RF_FunSel=01).
  - F HLT: go to HALT.
- Single-cycle ops return T2->T0; LD/ST go T2->T3->T0.
- HALT: idle outputs, Halted=1; stays until Reset.
- Reset mid-instruction: abort immediately to INIT; no partial write is issued after Reset rises.
- PC wrap: 0xFF increments to 0x00 (datapath behaviour); no special handling.

Decomposition:
Shared package holds:
- opcode constants (OP_LD..OP_HLT);
- ALU FunSel codes;
- register FunSel codes (DEC/INC/LOAD/CLR);
- mux select codes;
- state encodings;
- flag bit indices.

One natural sub-module, cu_decoder: combinational state/IR/Flags -> control word. The top keeps only the state register and next-state logic.

Test Plan:
- Reset pulse mid-T3 of ST -> next edge in INIT with Mem_CS=1, Mem_WR=0; following cycle RF_RegSel=0000, RF_FunSel=11, ARF_RegSel=000, ARF_FunSel=11; then T0.
- Program 0x2A05 (LDI R3,0x05) -> T0/T1 IR_LH 0 then 1 with PC inc; in T2 MuxASel=00, RF_RegSel=1011, RF_FunSel=10; next state T0.
- 0x0510 (LD R2,0x10) -> T2 ARF_RegSel=101, MuxBSel=01; T3 ARF_OutDSel=10, Mem_CS=0, MuxASel=01, RF_RegSel=1101.
- 0x4600 (ADD R2,R3) -> T2 ALU_FunSel=0100, MuxCSel=1, RF_OutASel=01, RF_OutBSel=10, MuxASel=11, RF_RegSel=1101.
- 0xD020 (BNE 0x20), Flags=0000 -> T2 PC load (ARF_RegSel=110, FunSel=10). With Flags=0001 -> all RegSels 1111/111.
- 0xF000 -> HALT; Halted=1 held for 10 cycles with Mem_CS=1 and IR_Enable=0 until Reset.
